uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver; the receive-side counterpart of the team's TX top. It takes the asynchronous serial line `rx` and recovers 8N1 frames: 1 start bit (low), 8 data bits LSB first, 1 stop bit (high). Bit timing comes from an internal divide-by-`div` counter, with a half-bit offset so each bit is sampled at its centre. Received bytes are presented on `rx_data` with a valid/ack handshake toward the APB register block, plus frame-error and overrun status.

Parameters:
- width, 16, bit width of the baud/sample counter; must satisfy 2^width > div.
- div, 16'd10417, clk cycles per bit period (100 MHz / 9600 baud). Minimum legal value is 4.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- arst  input  1  asynchronous active-low reset.
- rx  input  1  serial line, asynchronous to clk, idles high.
- rx_ack  input  1  single-cycle pulse; consumer has read rx_data.
- rx_data  output  8  last good received byte.
- rx_valid  output  1  level; rx_data holds an unacknowledged byte.
- done  output  1  one-cycle pulse on each good frame.
- frame_err  output  1  one-cycle pulse when the stop bit samples low.
- overrun  output  1  sticky; a good frame completed while rx_valid was already 1.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (arst=0, asynchronous):
  - rx_data=0, rx_valid=0, done=0, frame_err=0, overrun=0, busy=0.
  - State=IDLE, counter=0, bit index=0.
  - Both synchronizer flops and the edge-detect flop reset to 1.
  - Asserting reset mid-frame aborts the frame. No done or frame_err is emitted.
- Input conditioning:
  - 2-flop synchronizer produces rx_s.
  - Edge-detect register rx_q holds rx_s delayed one cycle.
  - fall = rx_q & ~rx_s.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - On fall, go to START with cnt=0.
  - Otherwise stay; cnt is held at 0.
- START:
  - cnt increments each cycle.
  - At cnt == (div>>1)-1, sample rx_s.
  - If rx_s=0, go to DATA with cnt=0, idx=0.
  - If rx_s=1 (glitch / false start), return to IDLE. No status output.
- DATA:
  - At cnt == div-1, shift rx_s into shift[7] with shift right (LSB first), clear cnt, increment idx.
  - After the 8th sample (idx==7), go to STOP with cnt=0.
- STOP:
  - At cnt == div-1, sample rx_s and go to IDLE in the same cycle. Returning mid-stop-bit allows back-to-back frames.
  - If rx_s=1:
    - rx_data <= shift and done=1 for the next cycle.
    - rx_valid <= 1.
    - If rx_valid was already 1 and rx_ack is not asserted in that cycle, overrun <= 1; the new byte overwrites rx_data.
  - If rx_s=0: frame_err=1 for one cycle. rx_data, rx_valid and overrun are unchanged.
- rx_ack:
  - Clears rx_valid and overrun on the next edge.
  - rx_ack in the same cycle as a good stop sample: rx_valid ends at 1, overrun is not set.
  - rx_ack while rx_valid=0 has no effect.
- Latency: edge 0 is the first clk edge at which rx is sampled low. done is high in the cycle after edge 2 + div/2 + 9*div.
- cnt never exceeds div-1. The counter wraps to 0 on every sample point. Width arithmetic is unsigned, in `width` bits.
- A rx falling edge seen outside IDLE is ignored; the start-bit search only runs in IDLE.

Test Plan:
- Reset/idle: div=16, hold arst=0 then release, rx=1 for 200 cycles -> all outputs 0, busy=0.
- Single byte: send 0xA5 at div=16 (16 clk/bit) -> done pulses exactly at edge 154 after the first low sample; rx_data=0xA5, rx_valid=1, frame_err=0. Pulse rx_ack -> rx_valid=0 next cycle.
- False start: rx low for 4 cycles, then high -> FSM returns to IDLE; busy high ≤ 10 cycles; no done or frame_err; rx_data unchanged.
- Frame error: send 0x3C with stop bit held low -> frame_err single pulse; done=0; rx_valid and rx_data keep their prior values.
- Back-to-back + overrun: send 0x11 then 0x22 with no idle gap and no ack -> two done pulses; rx_data=0x22, overrun=1. Then rx_ack -> overrun=0, rx_valid=0.
- Mid-frame reset: assert arst during data bit 4 of 0xFF -> outputs reset immediately. Next frame 0x5A -> received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// UART 8N1 receiver: synchronises rx, samples each bit at its centre, and hands
// bytes to the register block through a valid/ack handshake with error status.
module uart_rx #(
  parameter int unsigned width = 16,
  parameter int unsigned div   = 10417
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       done,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [width-1:0] bit_last  = width'(div - 1);
  localparam logic [width-1:0] half_last = width'((div >> 1) - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic             rx_meta;
  logic             rx_s;
  logic             rx_q;
  logic             fall;

  state_t           state,      state_nxt;
  logic [width-1:0] cnt,        cnt_nxt;
  logic [2:0]       idx,        idx_nxt;
  logic [7:0]       shift,      shift_nxt;
  logic [7:0]       data_nxt;
  logic             valid_nxt;
  logic             done_nxt;
  logic             ferr_nxt;
  logic             overrun_nxt;
  logic             busy_nxt;

  // Two-flop synchroniser plus edge-detect; idles high so reset never fakes a start.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_q    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_q    <= rx_s;
    end
  end

  assign fall = rx_q & ~rx_s;

  // Next-state and next-output logic.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    idx_nxt     = idx;
    shift_nxt   = shift;
    data_nxt    = rx_data;
    valid_nxt   = rx_valid;
    overrun_nxt = overrun;
    done_nxt    = 1'b0;
    ferr_nxt    = 1'b0;

    if (rx_ack) begin
      valid_nxt   = 1'b0;
      overrun_nxt = 1'b0;
    end

    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        if (fall) begin
          state_nxt = START;
        end
      end

      // Half-bit wait to land in the centre of the start bit; high there means a glitch.
      START: begin
        if (cnt == half_last) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + width'(1);
        end
      end

      DATA: begin
        if (cnt == bit_last) begin
          cnt_nxt   = '0;
          shift_nxt = {rx_s, shift[7:1]};
          idx_nxt   = idx + 3'(1);
          if (idx == 3'd7) begin
            state_nxt = STOP;
          end
        end else begin
          cnt_nxt = cnt + width'(1);
        end
      end

      // Leave at the stop-bit centre so a back-to-back start edge is not missed.
      STOP: begin
        if (cnt == bit_last) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          if (rx_s) begin
            data_nxt  = shift;
            done_nxt  = 1'b1;
            valid_nxt = 1'b1;
            if (rx_valid && !rx_ack) begin
              overrun_nxt = 1'b1;
            end
          end else begin
            ferr_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + width'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        idx_nxt   = '0;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      done      <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      shift     <= shift_nxt;
      rx_data   <= data_nxt;
      rx_valid  <= valid_nxt;
      done      <= done_nxt;
      frame_err <= ferr_nxt;
      overrun   <= overrun_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames scored
// against a frame-level model of the receive handshake.
module tb_uart_rx;

  localparam int unsigned DIV = 16;
  localparam int unsigned LAT = 2 + DIV / 2 + 9 * DIV;

  logic       clk = 1'b0;
  logic       arst = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       done;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int fe_cnt = 0;
  int fe_cyc = 0;
  int busy_cycles = 0;
  logic [7:0] done_data = 8'h00;

  logic [7:0] exp_data;
  logic       exp_valid;
  logic       exp_overrun;
  int         d0;
  int         f0;

  uart_rx #(.width(16), .div(DIV)) dut (
    .clk       (clk),
    .arst      (arst),
    .rx        (rx),
    .rx_ack    (rx_ack),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .done      (done),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (done) begin
      done_cnt  <= done_cnt + 1;
      done_cyc  <= cyc;
      done_data <= rx_data;
    end
    if (frame_err) begin
      fe_cnt <= fe_cnt + 1;
      fe_cyc <= cyc;
    end
    if (busy) busy_cycles <= busy_cycles + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one 10-bit frame starting at the current negedge.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    start_cyc = cyc + 1;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(DIV);
    end
    rx = stop;
    tick(DIV);
    rx = 1'b1;
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_data"},    32'(rx_data),  32'(exp_data));
    check({tag, "_valid"},   32'(rx_valid), 32'(exp_valid));
    check({tag, "_overrun"}, 32'(overrun),  32'(exp_overrun));
  endtask

  initial begin
    exp_data = 8'h00; exp_valid = 1'b0; exp_overrun = 1'b0;

    // Reset and idle line.
    tick(3);
    #1;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check_outputs("rst");
    @(negedge clk);
    arst = 1'b1;
    tick(200);
    check("idle_busy", 32'(busy), 32'(0));
    check("idle_ferr", 32'(frame_err), 32'(0));
    check("idle_done_cnt", 32'(done_cnt), 32'(0));
    check_outputs("idle");

    // Single byte with exact latency.
    send_frame(8'hA5, 1'b1);
    check("a5_done_cnt", 32'(done_cnt), 32'(1));
    check("a5_latency", 32'(done_cyc - start_cyc), 32'(LAT));
    check("a5_done_data", 32'(done_data), 32'(8'hA5));
    check("a5_ferr_cnt", 32'(fe_cnt), 32'(0));
    exp_data = 8'hA5; exp_valid = 1'b1;
    check_outputs("a5");

    // Stop bit held low: frame error, previous byte untouched.
    tick(10);
    send_frame(8'h3C, 1'b0);
    tick(10);
    check("fe_cnt", 32'(fe_cnt), 32'(1));
    check("fe_latency", 32'(fe_cyc - start_cyc), 32'(LAT));
    check("fe_done_cnt", 32'(done_cnt), 32'(1));
    check_outputs("fe");

    ack_pulse();
    exp_valid = 1'b0;
    check_outputs("ack1");

    // False start: short low glitch.
    tick(10);
    busy_cycles = 0;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(30);
    check("fs_busy_bounded", 32'(busy_cycles >= 1 && busy_cycles <= 10), 32'(1));
    check("fs_busy_now", 32'(busy), 32'(0));
    check("fs_done_cnt", 32'(done_cnt), 32'(1));
    check("fs_fe_cnt", 32'(fe_cnt), 32'(1));
    check_outputs("fs");

    // Back-to-back frames without ack produce an overrun.
    d0 = done_cnt;
    send_frame(8'h11, 1'b1);
    check("b2b_first_data", 32'(done_data), 32'(8'h11));
    send_frame(8'h22, 1'b1);
    check("b2b_second_latency", 32'(done_cyc - start_cyc), 32'(LAT));
    tick(2);
    check("b2b_done_cnt", 32'(done_cnt - d0), 32'(2));
    exp_data = 8'h22; exp_valid = 1'b1; exp_overrun = 1'b1;
    check_outputs("b2b");

    // Ack coincident with the good stop sample: valid stays, overrun clears.
    fork
      send_frame(8'h33, 1'b1);
      begin
        tick(LAT);
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
      end
    join
    exp_data = 8'h33; exp_valid = 1'b1; exp_overrun = 1'b0;
    check_outputs("coack");

    ack_pulse();
    exp_valid = 1'b0;
    check_outputs("ack2");
    ack_pulse();
    check_outputs("ack_idle");

    // Reset during data bit 4 aborts the frame.
    d0 = done_cnt;
    f0 = fe_cnt;
    tick(5);
    send_frame(8'h44, 1'b1);
    tick(3);
    rx = 1'b0;
    tick(DIV);
    rx = 1'b1;
    tick(4 * DIV + DIV / 2);
    arst = 1'b0;
    #1;
    check("mrst_busy", 32'(busy), 32'(0));
    exp_data = 8'h00; exp_valid = 1'b0; exp_overrun = 1'b0;
    check_outputs("mrst");
    tick(4);
    arst = 1'b1;
    tick(20 + 5 * DIV);
    check("mrst_done_cnt", 32'(done_cnt - d0), 32'(1));
    check("mrst_fe_cnt", 32'(fe_cnt - f0), 32'(0));
    send_frame(8'h5A, 1'b1);
    check("post_rst_data", 32'(done_data), 32'(8'h5A));
    check("post_rst_latency", 32'(done_cyc - start_cyc), 32'(LAT));
    exp_data = 8'h5A; exp_valid = 1'b1;
    check_outputs("post_rst");

    // Random frames scored against the handshake model.
    for (int n = 0; n < 8; n++) begin
      logic [7:0] b;
      int         gap;
      logic       do_ack;
      b      = 8'($urandom);
      gap    = int'($urandom_range(0, 20));
      do_ack = 1'($urandom_range(0, 1));
      d0     = done_cnt;
      send_frame(b, 1'b1);
      check("rnd_done_cnt", 32'(done_cnt - d0), 32'(1));
      check("rnd_done_data", 32'(done_data), 32'(b));
      check("rnd_latency", 32'(done_cyc - start_cyc), 32'(LAT));
      if (exp_valid) exp_overrun = 1'b1;
      exp_valid = 1'b1;
      exp_data  = b;
      check_outputs("rnd_frame");
      if (do_ack) begin
        ack_pulse();
        exp_valid   = 1'b0;
        exp_overrun = 1'b0;
        check_outputs("rnd_ack");
      end
      tick(gap);
    end
    check("rnd_fe_cnt", 32'(fe_cnt - f0), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
